// File: rtl/i2c_bus_arbiter.sv
// Shares one byte-level I2C engine between NUM_REQ sequencers, locked per START..STOP, round-robin.
// Optional idle-owner forced release is compiled in with `define I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [2*NUM_REQ-1:0]   req_instruction,
   input  logic [NUM_REQ-1:0]     req_enable,
   input  logic [8*NUM_REQ-1:0]   req_byte_to_send,
   output logic [7:0]             req_byte_received,
   output logic [NUM_REQ-1:0]     req_complete,
   output logic [NUM_REQ-1:0]     grant,
   output logic [1:0]             i2c_instruction,
   output logic                   i2c_enable,
   output logic [7:0]             i2c_byte_to_send,
   input  logic [7:0]             i2c_byte_received,
   input  logic                   i2c_complete,
   output logic                   timeout_pulse
);

   localparam int IW = $clog2(NUM_REQ);
   localparam logic [1:0] INS_START = 2'd0;
   localparam logic [1:0] INS_STOP  = 2'd1;

   typedef enum logic [1:0] {IDLE, OWNED, STOP_WAIT} state_t;

   state_t             state, state_next;
   logic [IW-1:0]      owner, owner_next, rr, rr_next, winner, owner_inc;
   logic [NUM_REQ-1:0] grant_next;
   logic [1:0]         ins_next, own_ins;
   logic [7:0]         byte_next, own_byte;
   logic               en_next, own_en, found, stop_seen, stop_seen_next, release_now;
   int                 idx;

   assign own_ins   = req_instruction[2*owner +: 2];
   assign own_en    = req_enable[owner];
   assign own_byte  = req_byte_to_send[8*owner +: 8];
   assign owner_inc = (owner == IW'(NUM_REQ-1)) ? '0 : owner + 1'b1;

   assign req_byte_received = i2c_byte_received;
   assign req_complete      = (state == OWNED) ? (grant & {NUM_REQ{i2c_complete}}) : '0;

   // First START request at or after the round-robin pointer, wrapping modulo NUM_REQ.
   always_comb begin
      // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_enable[idx] && req_instruction[2*idx +: 2] == INS_START) begin
            found  = 1'b1;
            winner = IW'(idx);
         end
      end
   end

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] idle_cnt;
   logic          owner_idle, timeout_hit, busy_seen, pulse_next;

   assign owner_idle  = !own_en && !i2c_enable;
   assign timeout_hit = owner_idle && (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt      <= '0;
         busy_seen     <= 1'b0;
         timeout_pulse <= 1'b0;
      end else begin
         idle_cnt      <= (state == OWNED && owner_idle) ? idle_cnt + 1'b1 : '0;
         // A stale complete may linger until the engine takes our STOP; wait to see it busy.
         busy_seen     <= (state == STOP_WAIT) && (busy_seen || !i2c_complete);
         timeout_pulse <= pulse_next;
      end
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign timeout_pulse      = 1'b0;
`endif

   assign release_now = stop_seen && i2c_complete && !own_en;

   always_comb begin
      state_next     = state;
      owner_next     = owner;
      rr_next        = rr;
      grant_next     = grant;
      ins_next       = i2c_instruction;
      en_next        = i2c_enable;
      byte_next      = i2c_byte_to_send;
      stop_seen_next = stop_seen;
`ifdef I2C_ARB_TIMEOUT_EN
      pulse_next     = 1'b0;
`endif
      case (state)
         IDLE: begin
            en_next = 1'b0;
            if (found) begin
               state_next     = OWNED;
               owner_next     = winner;
               grant_next     = NUM_REQ'(1) << winner;
               ins_next       = req_instruction[2*winner +: 2];
               en_next        = req_enable[winner];
               byte_next      = req_byte_to_send[8*winner +: 8];
               stop_seen_next = 1'b0;
            end
         end
         OWNED: begin
            ins_next  = own_ins;
            en_next   = own_en;
            byte_next = own_byte;
            if (own_en && own_ins == INS_STOP) stop_seen_next = 1'b1;
            if (release_now) begin
               state_next = IDLE;
               grant_next = '0;
               en_next    = 1'b0;
               rr_next    = owner_inc;
            end
`ifdef I2C_ARB_TIMEOUT_EN
            else if (timeout_hit) begin
               state_next = STOP_WAIT;
               ins_next   = INS_STOP;
               en_next    = 1'b1;
            end
`endif
         end
`ifdef I2C_ARB_TIMEOUT_EN
         STOP_WAIT: begin
            ins_next = INS_STOP;
            en_next  = 1'b1;
            if (busy_seen && i2c_complete) begin
               state_next = IDLE;
               grant_next = '0;
               en_next    = 1'b0;
               rr_next    = owner_inc;
               pulse_next = 1'b1;
            end
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         owner            <= '0;
         rr               <= '0;
         grant            <= '0;
         i2c_instruction  <= 2'd0;
         i2c_enable       <= 1'b0;
         i2c_byte_to_send <= 8'd0;
         stop_seen        <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state            <= state_next;
         owner            <= owner_next;
         rr               <= rr_next;
         grant            <= grant_next;
         i2c_instruction  <= ins_next;
         i2c_enable       <= en_next;
         i2c_byte_to_send <= byte_next;
         stop_seen        <= stop_seen_next;
      end
   end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: a 2-requester and a 3-requester instance share clock and engine inputs.
module tb_i2c_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmp = 1'b0;
   logic [7:0]  rxb = 8'h00;

   logic [3:0]  r2_ins = '0;
   logic [1:0]  r2_en = '0;
   logic [15:0] r2_byte = '0;
   logic [7:0]  rb2;
   logic [1:0]  rc2, g2, i2_ins;
   logic        i2_en, tp2;
   logic [7:0]  i2_byte;

   logic [5:0]  r3_ins = '0;
   logic [2:0]  r3_en = '0;
   logic [23:0] r3_byte = '0;
   logic [7:0]  rb3;
   logic [2:0]  rc3, g3;
   logic [1:0]  i3_ins;
   logic        i3_en, tp3;
   logic [7:0]  i3_byte;

   int total = 0;
   int bad = 0;
   int pulses2 = 0;
   bit seen;

   always #5 clk = ~clk;
   always @(posedge clk) if (tp2) pulses2++;

   i2c_bus_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(16)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .req_instruction(r2_ins), .req_enable(r2_en), .req_byte_to_send(r2_byte),
      .req_byte_received(rb2), .req_complete(rc2), .grant(g2),
      .i2c_instruction(i2_ins), .i2c_enable(i2_en), .i2c_byte_to_send(i2_byte),
      .i2c_byte_received(rxb), .i2c_complete(cmp), .timeout_pulse(tp2)
   );

   i2c_bus_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(16)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .req_instruction(r3_ins), .req_enable(r3_en), .req_byte_to_send(r3_byte),
      .req_byte_received(rb3), .req_complete(rc3), .grant(g3),
      .i2c_instruction(i3_ins), .i2c_enable(i3_en), .i2c_byte_to_send(i3_byte),
      .i2c_byte_received(rxb), .i2c_complete(cmp), .timeout_pulse(tp3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Owner i of dut2 issues STOP, engine completes it, owner drops enable (release edge).
   task automatic stop2(input int i);
      r2_ins[2*i +: 2] = 2'd1;
      r2_en[i] = 1'b1;
      step();
      cmp = 1'b0;
      step();
      cmp = 1'b1;
      r2_en[i] = 1'b0;
      step();
   endtask

   // Finish the pending START of owner i, then run its STOP.
   task automatic finish2(input int i);
      cmp = 1'b0;
      step();
      cmp = 1'b1;
      r2_en[i] = 1'b0;
      step();
      stop2(i);
   endtask

   task automatic finish3(input int i);
      cmp = 1'b0;
      step();
      cmp = 1'b1;
      r3_en[i] = 1'b0;
      step();
      r3_ins[2*i +: 2] = 2'd1;
      r3_en[i] = 1'b1;
      step();
      cmp = 1'b0;
      step();
      cmp = 1'b1;
      r3_en[i] = 1'b0;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      step();
      step();
      check("rst_grant", g2, 2'b00);
      check("rst_i2c_en", i2_en, 1'b0);
      check("rst_i2c_ins", i2_ins, 2'd0);
      check("rst_i2c_byte", i2_byte, 8'h00);
      check("rst_tpulse", tp2, 1'b0);
      cmp = 1'b1;
      #1;
      check("rst_req_complete", rc2, 2'b00);
      rst_n = 1'b1;
      step();

      // Both request START together: req0 wins, req1 waits for req0's STOP
      r2_ins = 4'b0000;
      r2_en  = 2'b11;
      step();
      check("t1_grant_first", g2, 2'b01);
      check("t1_i2c_en", i2_en, 1'b1);
      check("t1_i2c_ins", i2_ins, 2'd0);
      cmp = 1'b0;
      step();
      cmp = 1'b1;
      #1;
      check("t1_complete_routed", rc2, 2'b01);
      r2_en = 2'b10;
      step();
      check("t1_still_owner", g2, 2'b01);
      check("t1_en_dropped", i2_en, 1'b0);

      // Owner READ while req1 wiggles its inputs
      r2_ins = 4'b0010;
      r2_byte[7:0] = 8'h55;
      r2_en = 2'b11;
      step();
      check("t3_read_ins", i2_ins, 2'd2);
      check("t3_read_byte", i2_byte, 8'h55);
      r2_ins = 4'b1110;
      r2_byte[15:8] = 8'hAA;
      r2_en = 2'b01;
      step();
      check("t3_nonowner_ins", i2_ins, 2'd2);
      check("t3_nonowner_byte", i2_byte, 8'h55);
      check("t3_nonowner_en", i2_en, 1'b1);
      r2_en = 2'b11;
      cmp = 1'b0;
      step();
      rxb = 8'h0E;
      cmp = 1'b1;
      #1;
      check("t3_rx_byte", rb2, 8'h0E);
      check("t3_rx_complete", rc2, 2'b01);
      r2_ins = 4'b0010;
      r2_en = 2'b10;
      step();
      check("t3_owner_kept", g2, 2'b01);

      // Owner STOP; req1 granted one cycle after release
      r2_ins = 4'b0001;
      r2_en = 2'b11;
      step();
      check("t1_stop_ins", i2_ins, 2'd1);
      check("t1_stop_en", i2_en, 1'b1);
      cmp = 1'b0;
      step();
      cmp = 1'b1;
      #1;
      check("t1_stop_complete", rc2, 2'b01);
      r2_en = 2'b10;
      step();
      check("t1_release_grant", g2, 2'b00);
      check("t1_release_en", i2_en, 1'b0);
      step();
      check("t1_grant_second", g2, 2'b10);
      finish2(1);
      step();
      check("t1_bus_free", g2, 2'b00);

      // Non-START request while unowned is ignored
      r2_ins = 4'b1100;
      r2_byte[15:8] = 8'h6C;
      r2_en = 2'b10;
      cmp = 1'b1;
      repeat (4) step();
      check("t2_no_grant", g2, 2'b00);
      check("t2_no_enable", i2_en, 1'b0);
      check("t2_no_complete", rc2, 2'b00);
      r2_en = 2'b00;
      step();

      // Three requesters: move pointer to 2, then 0 and 1 request together
      r3_ins = '0;
      r3_en = 3'b010;
      step();
      check("t4_grant_1", g3, 3'b010);
      finish3(1);
      step();
      check("t4_free", g3, 3'b000);
      r3_ins = '0;
      r3_en = 3'b011;
      step();
      check("t4_wrap_to_0", g3, 3'b001);
      cmp = 1'b0;
      step();
      cmp = 1'b1;
      r3_en = 3'b010;
      step();
      r3_ins[1:0] = 2'd1;
      r3_en = 3'b011;
      step();
      cmp = 1'b0;
      step();
      cmp = 1'b1;
      r3_en = 3'b010;
      step();
      check("t4_release_0", g3, 3'b000);
      step();
      check("t4_then_1", g3, 3'b010);
      finish3(1);
      step();

      // Idle owner
      r2_ins = 4'b0000;
      r2_en = 2'b01;
      step();
      check("t5_grant", g2, 2'b01);
      cmp = 1'b0;
      step();
      cmp = 1'b1;
      r2_en = 2'b10;
      step();
`ifdef I2C_ARB_TIMEOUT_EN
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         step();
         if (i2_en && i2_ins == 2'd1) seen = 1'b1;
      end
      check("t5_forced_stop", seen, 1'b1);
      check("t5_complete_masked", rc2, 2'b00);
      check("t5_owner_held", g2, 2'b01);
      cmp = 1'b0;
      step();
      cmp = 1'b1;
      step();
      check("t5_pulse", tp2, 1'b1);
      check("t5_released", g2, 2'b00);
      check("t5_en_dropped", i2_en, 1'b0);
      step();
      check("t5_pulse_once", tp2, 1'b0);
      check("t5_next_grant", g2, 2'b10);
      finish2(1);
      step();
      check("t5_pulse_count", pulses2, 1);
`else
      repeat (30) step();
      check("t5_bus_held", g2, 2'b01);
      check("t5_no_pulse", tp2, 1'b0);
      r2_en = 2'b00;
      stop2(0);
      r2_ins = 4'b0000;
      r2_en = 2'b10;
      step();
      check("t5_next_grant", g2, 2'b10);
      finish2(1);
      step();
      check("t5_pulse_count", pulses2, 0);
`endif

      // Reset in the middle of a WRITE
      r2_ins = 4'b0000;
      r2_en = 2'b01;
      step();
      check("t6_grant", g2, 2'b01);
      cmp = 1'b0;
      step();
      cmp = 1'b1;
      r2_en = 2'b00;
      step();
      r2_ins = 4'b0011;
      r2_byte[7:0] = 8'h5A;
      r2_en = 2'b01;
      step();
      check("t6_write_en", i2_en, 1'b1);
      check("t6_write_byte", i2_byte, 8'h5A);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_grant", g2, 2'b00);
      check("t6_async_en", i2_en, 1'b0);
      step();
      rst_n = 1'b1;
      r2_en = 2'b00;
      step();
      r2_ins = 4'b0000;
      r2_en = 2'b10;
      step();
      check("t6_fresh_grant", g2, 2'b10);
      finish2(1);
      step();
      check("t6_final_free", g2, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
